// File: rtl/mem_port_initiator.sv
// CPU-side initiator for the cache/DDR2 memory handshake.
// Serves one load/store at a time; byte/half stores are done as read-modify-write.
module mem_port_initiator #(
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned GAP     = 1,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       write_data,
  output logic              read_or_write,
  output logic              memory_sig,
  input  logic [31:0]       read_data,
  input  logic              finish
);

  localparam int unsigned      CNT_MAX  = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int unsigned      CNT_W    = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
  localparam logic [31:0]      HI_MASK  = (ADDR_W >= 32) ? 32'h0 : ~((32'h1 << ADDR_W) - 32'h1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WR, S_RMW_RD, S_MERGE, S_RMW_WR, S_GAP, S_RESP
  } state_t;

  state_t             r_state;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_mem_sig;
  logic               r_rw;
  logic [ADDR_W-1:0]  r_addr;
  logic [31:0]        r_wr_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [1:0]         r_size;
  logic               r_unsigned;
  logic [1:0]         r_lane;
  logic [15:0]        r_wdata;
  logic               r_err;
  logic [31:0]        r_rdword;

  logic               w_accept;
  logic               w_bad;
  logic               w_timeout;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [31:0]        w_load;
  logic [31:0]        w_merged;

  assign req_ready     = r_req_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_err       = r_rsp_err;
  assign addr          = r_addr;
  assign write_data    = r_wr_data;
  assign read_or_write = r_rw;
  assign memory_sig    = r_mem_sig;

  assign w_accept  = req_valid && r_req_ready;
  assign w_bad     = (req_size == 2'd3)
                  || ((req_size == 2'd1) && req_addr[0])
                  || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00))
                  || ((req_addr & HI_MASK) != 32'h0);
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte   = r_rdword[{r_lane, 3'b000} +: 8];
    w_half   = r_rdword[{r_lane[1], 4'b0000} +: 16];
    w_load   = r_rdword;
    if (r_size == 2'd0) begin
      w_load = r_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
    end else if (r_size == 2'd1) begin
      w_load = r_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
    end
    w_merged = r_rdword;
    if (r_size == 2'd0) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_mem_sig   <= 1'b0;
      r_rw        <= 1'b1;
      r_addr      <= '0;
      r_wr_data   <= 32'h0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_unsigned  <= 1'b0;
      r_lane      <= 2'd0;
      r_wdata     <= 16'h0;
      r_err       <= 1'b0;
      r_rdword    <= 32'h0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= !w_accept;
          if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_lane     <= req_addr[1:0];
            r_wdata    <= req_wdata[15:0];
            r_err      <= w_bad;
            if (w_bad) begin
              // Rejected requests never touch the memory port.
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= 32'h0;
            end else begin
              r_addr    <= {req_addr[ADDR_W-1:2], 2'b00};
              r_mem_sig <= 1'b1;
              r_cnt     <= '0;
              if (!req_we) begin
                r_state <= S_RD;
              end else if (req_size == 2'd2) begin
                r_state   <= S_WR;
                r_rw      <= 1'b0;
                r_wr_data <= req_wdata;
              end else begin
                r_state <= S_RMW_RD;
              end
            end
          end
        end
        S_RD, S_RMW_RD, S_WR, S_RMW_WR: begin
          // Finish wins over a timeout landing in the same cycle.
          if (finish || w_timeout) begin
            r_mem_sig <= 1'b0;
            r_rw      <= 1'b1;
            r_cnt     <= '0;
            if (finish && r_rw) r_rdword <= read_data;
            if (finish && (r_state == S_RMW_RD)) begin
              r_state <= S_MERGE;
            end else begin
              r_state <= S_GAP;
              r_err   <= !finish;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_MERGE: begin
          r_wr_data <= w_merged;
          r_rw      <= 1'b0;
          r_mem_sig <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_RMW_WR;
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_rsp_rdata <= (!r_we && !r_err) ? w_load : 32'h0;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
